// File: rtl/mig_app_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mig_app_pkg
// Description : Shared command codes, controller states and address-to-index
//               helper for the MIG app-interface responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mig_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [0:0] {
        ST_CALIB = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // MIG addresses advance by 8 per DATA_W word; bits [2:0] and everything
    // above the memory depth are dropped so addresses alias.
    function automatic logic [31:0] addr_to_index(input logic [63:0] addr,
                                                  input int          depth_log2);
        logic [63:0] word;
        logic [63:0] keep;
        word = addr >> 3;
        keep = (64'd1 << depth_log2) - 64'd1;
        return 32'(word & keep);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count and show-ahead read
//               data. Push when full and pop when empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign pop_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage array: payload only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mig_app_responder.sv
`default_nettype none
// ============================================================================
// Module      : mig_app_responder
// Description : BRAM-backed stand-in for the MIG 7-series app_* interface.
//               Calibration delay, periodic refresh stall, queued writes with
//               byte masks and fixed-latency in-order reads.
// Revision    : 1.0 - initial release
// ============================================================================
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int ADDR_W       = 29,
    parameter int DATA_W       = 256,
    parameter int MASK_W       = 32,
    parameter int DEPTH_LOG2   = 6,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 16,
    parameter int STALL_PERIOD = 64,
    parameter int WQ_DEPTH     = 4
) (
    input  logic              ui_clk,
    input  logic              ui_clk_sync_rst,
    input  logic [ADDR_W-1:0] app_addr,
    input  logic [2:0]        app_cmd,
    input  logic              app_en,
    output logic              app_rdy,
    input  logic [DATA_W-1:0] app_wdf_data,
    input  logic [MASK_W-1:0] app_wdf_mask,
    input  logic              app_wdf_wren,
    input  logic              app_wdf_end,
    output logic              app_wdf_rdy,
    output logic [DATA_W-1:0] app_rd_data,
    output logic              app_rd_data_valid,
    output logic              app_rd_data_end,
    output logic              init_calib_complete,
    output logic              cmd_err
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(WQ_DEPTH + 1);
    localparam int CAL_W = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
    localparam int WQ_W  = DATA_W + MASK_W;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [CAL_W-1:0]      r_calib_cnt;
    logic                  r_calib_done;
    logic                  r_cmd_err;
    logic [DATA_W-1:0]     r_mem      [0:WORDS-1];
    logic [RD_LATENCY-1:0] r_vld_pipe;
    logic [DATA_W-1:0]     r_dat_pipe [0:RD_LATENCY-1];

    logic                  w_run;
    logic                  w_stall;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_cmd_acc;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_bad_acc;
    logic                  w_dat_acc;
    logic                  w_cmd_avail;
    logic                  w_dat_avail;
    logic                  w_commit;
    logic [DEPTH_LOG2-1:0] w_commit_idx;
    logic [WQ_W-1:0]       w_commit_word;
    logic [DATA_W-1:0]     w_commit_data;
    logic [MASK_W-1:0]     w_commit_mask;
    logic [DATA_W-1:0]     w_rd_word;

    logic                  w_wcmd_push;
    logic                  w_wcmd_pop;
    logic [DEPTH_LOG2-1:0] w_wcmd_head;
    logic [CNT_W-1:0]      w_wcmd_cnt;
    logic                  w_wcmd_empty;
    logic                  w_wcmd_full;

    logic                  w_wdat_push;
    logic                  w_wdat_pop;
    logic [WQ_W-1:0]       w_wdat_head;
    logic [CNT_W-1:0]      w_wdat_cnt;
    logic                  w_wdat_empty;
    logic                  w_wdat_full;

    logic                  w_unused_ok;

    // ------------------------------------------------------------------
    // Calibration state machine: CALIB counts out, then RUN forever.
    // ------------------------------------------------------------------
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_state      <= ST_CALIB;
            r_calib_cnt  <= '0;
            r_calib_done <= 1'b0;
        end else begin
            case (r_state)
                ST_CALIB: begin
                    if (r_calib_cnt == CAL_W'(CALIB_CYCLES - 1)) begin
                        r_state      <= ST_RUN;
                        r_calib_done <= 1'b1;
                    end else begin
                        r_calib_cnt <= r_calib_cnt + CAL_W'(1);
                    end
                end
                ST_RUN: begin
                    r_calib_done <= 1'b1;
                end
                default: begin
                    r_state      <= ST_CALIB;
                    r_calib_done <= 1'b0;
                end
            endcase
        end
    end

    assign w_run = (r_state == ST_RUN);

    // ------------------------------------------------------------------
    // Refresh stall: one dead command cycle every STALL_PERIOD cycles.
    // ------------------------------------------------------------------
    generate
        if (STALL_PERIOD > 0) begin : g_stall
            localparam int SP_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
            logic [SP_W-1:0] r_stall_cnt;

            // Free-running modulo counter, restarted by reset.
            always_ff @(posedge ui_clk) begin
                if (ui_clk_sync_rst) begin
                    r_stall_cnt <= '0;
                end else if (r_stall_cnt == SP_W'(STALL_PERIOD - 1)) begin
                    r_stall_cnt <= '0;
                end else begin
                    r_stall_cnt <= r_stall_cnt + SP_W'(1);
                end
            end

            assign w_stall = (r_stall_cnt == SP_W'(STALL_PERIOD - 1));
        end else begin : g_no_stall
            assign w_stall = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake. Both readies come from registers only; an outstanding
    // write command blocks further commands, which keeps reads behind
    // earlier writes.
    // ------------------------------------------------------------------
    assign app_rdy     = w_run & ~w_stall & (w_wcmd_cnt == '0);
    assign app_wdf_rdy = w_run & (w_wdat_cnt < CNT_W'(WQ_DEPTH));

    assign w_idx     = DEPTH_LOG2'(addr_to_index(64'(app_addr), DEPTH_LOG2));
    assign w_cmd_acc = app_en & app_rdy;
    assign w_wr_acc  = w_cmd_acc & (app_cmd == CMD_WRITE);
    assign w_rd_acc  = w_cmd_acc & (app_cmd == CMD_READ);
    assign w_bad_acc = w_cmd_acc & (app_cmd != CMD_WRITE) & (app_cmd != CMD_READ);
    assign w_dat_acc = app_wdf_wren & app_wdf_rdy;

    // Oldest command pairs with oldest data; an empty queue is bypassed by
    // the same-cycle beat so a combined stream commits every cycle.
    assign w_cmd_avail   = ~w_wcmd_empty | w_wr_acc;
    assign w_dat_avail   = ~w_wdat_empty | w_dat_acc;
    assign w_commit      = w_cmd_avail & w_dat_avail;
    assign w_commit_idx  = w_wcmd_empty ? w_idx : w_wcmd_head;
    assign w_commit_word = w_wdat_empty ? {app_wdf_mask, app_wdf_data} : w_wdat_head;
    assign w_commit_data = w_commit_word[DATA_W-1:0];
    assign w_commit_mask = w_commit_word[WQ_W-1:DATA_W];

    assign w_wcmd_push = w_wr_acc & ~w_commit;
    assign w_wcmd_pop  = w_commit & ~w_wcmd_empty;
    assign w_wdat_push = w_dat_acc & ~(w_commit & w_wdat_empty);
    assign w_wdat_pop  = w_commit & ~w_wdat_empty;

    sync_fifo #(
        .WIDTH (DEPTH_LOG2),
        .DEPTH (WQ_DEPTH)
    ) u_wcmd_q (
        .clk       (ui_clk),
        .rst       (ui_clk_sync_rst),
        .push      (w_wcmd_push),
        .push_data (w_idx),
        .pop       (w_wcmd_pop),
        .pop_data  (w_wcmd_head),
        .count     (w_wcmd_cnt),
        .empty     (w_wcmd_empty),
        .full      (w_wcmd_full)
    );

    sync_fifo #(
        .WIDTH (WQ_W),
        .DEPTH (WQ_DEPTH)
    ) u_wdat_q (
        .clk       (ui_clk),
        .rst       (ui_clk_sync_rst),
        .push      (w_wdat_push),
        .push_data ({app_wdf_mask, app_wdf_data}),
        .pop       (w_wdat_pop),
        .pop_data  (w_wdat_head),
        .count     (w_wdat_cnt),
        .empty     (w_wdat_empty),
        .full      (w_wdat_full)
    );

    // Memory commit: mask bit set means that byte is left untouched.
    // No reset so contents survive ui_clk_sync_rst.
    always_ff @(posedge ui_clk) begin
        if (w_commit) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!w_commit_mask[b]) begin
                    r_mem[w_commit_idx][8*b +: 8] <= w_commit_data[8*b +: 8];
                end
            end
        end
    end

    assign w_rd_word = r_mem[w_idx];

    // Read return pipeline; reset discards anything in flight.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_dat_pipe[i] <= '0;
            end
        end else begin
            r_vld_pipe[0] <= w_rd_acc;
            r_dat_pipe[0] <= w_rd_word;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_dat_pipe[i] <= r_dat_pipe[i-1];
            end
        end
    end

    // Sticky flag for accepted commands other than read/write.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_cmd_err <= 1'b0;
        end else if (w_bad_acc) begin
            r_cmd_err <= 1'b1;
        end
    end

    assign app_rd_data         = r_dat_pipe[RD_LATENCY-1];
    assign app_rd_data_valid   = r_vld_pipe[RD_LATENCY-1];
    assign app_rd_data_end     = r_vld_pipe[RD_LATENCY-1];
    assign init_calib_complete = r_calib_done;
    assign cmd_err             = r_cmd_err;

    // Single-beat bursts make app_wdf_end redundant with app_wdf_wren.
    assign w_unused_ok = ^{app_wdf_end, w_wcmd_full, w_wdat_full};

endmodule
`default_nettype wire

// File: tb/tb_mig_app_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mig_app_responder
// Description : Directed self-checking bench with a read-data scoreboard
//               and a byte-accurate memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mig_app_responder;
    import mig_app_pkg::*;

    localparam int ADDR_W       = 29;
    localparam int DATA_W       = 256;
    localparam int MASK_W       = 32;
    localparam int DEPTH_LOG2   = 6;
    localparam int RD_LATENCY   = 4;
    localparam int CALIB_CYCLES = 16;
    localparam int STALL_PERIOD = 8;
    localparam int WQ_DEPTH     = 4;

    logic              ui_clk = 1'b0;
    logic              ui_clk_sync_rst = 1'b1;
    logic [ADDR_W-1:0] app_addr = '0;
    logic [2:0]        app_cmd = '0;
    logic              app_en = 1'b0;
    logic              app_rdy;
    logic [DATA_W-1:0] app_wdf_data = '0;
    logic [MASK_W-1:0] app_wdf_mask = '0;
    logic              app_wdf_wren = 1'b0;
    logic              app_wdf_end = 1'b0;
    logic              app_wdf_rdy;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_valid;
    logic              app_rd_data_end;
    logic              init_calib_complete;
    logic              cmd_err;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] model [0:63];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int rel0 = 0;
    bit stall_chk = 1'b0;

    mig_app_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .DEPTH_LOG2(DEPTH_LOG2),
        .RD_LATENCY(RD_LATENCY), .CALIB_CYCLES(CALIB_CYCLES),
        .STALL_PERIOD(STALL_PERIOD), .WQ_DEPTH(WQ_DEPTH)
    ) dut (
        .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete),
        .cmd_err(cmd_err)
    );

    always #5 ui_clk = ~ui_clk;

    always @(posedge ui_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [ADDR_W-1:0] a);
        return int'(a / 8) % 64;
    endfunction

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic [MASK_W-1:0] m);
        for (int b = 0; b < MASK_W; b++)
            if (!m[b]) model[word_of(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    // Drive a command and/or data beat; returns #1 after the last accepting edge.
    task automatic xfer(input bit do_cmd, input logic [2:0] cmd, input logic [ADDR_W-1:0] a,
                        input bit do_dat, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        bit cdone;
        bit ddone;
        int t;
        cdone = !do_cmd;
        ddone = !do_dat;
        app_en = do_cmd; app_cmd = cmd; app_addr = a;
        app_wdf_wren = do_dat; app_wdf_end = do_dat; app_wdf_data = d; app_wdf_mask = m;
        t = 0;
        while (!(cdone && ddone) && t < 200) begin
            @(negedge ui_clk);
            if (app_en && app_rdy) begin
                cdone = 1'b1;
                if (cmd == CMD_READ) sb.push_back('{model[word_of(a)], cyc + RD_LATENCY});
            end
            if (app_wdf_wren && app_wdf_rdy) ddone = 1'b1;
            @(posedge ui_clk); #1;
            if (cdone) app_en = 1'b0;
            if (ddone) begin app_wdf_wren = 1'b0; app_wdf_end = 1'b0; end
            t++;
        end
        check("handshake_done", {cdone, ddone}, 2'b11);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [MASK_W-1:0] m);
        xfer(1'b1, CMD_WRITE, a, 1'b1, d, m);
        model_write(a, d, m);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        xfer(1'b1, CMD_READ, a, 1'b0, '0, '0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin @(posedge ui_clk); t++; end
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    // Read-return monitor and refresh-stall pattern check.
    always @(negedge ui_clk) begin
        exp_t e;
        if (app_rd_data_valid === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_valid: observed valid=1 expected no read outstanding");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rd_data", app_rd_data, e.data);
                check("rd_cycle", cyc, e.due);
                check("rd_end", app_rd_data_end, 1'b1);
            end
        end
        if (stall_chk) check("stall_rdy", app_rdy, ((cyc - rel0) % STALL_PERIOD) != STALL_PERIOD - 1);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed time limit expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values.
        repeat (3) @(posedge ui_clk);
        @(negedge ui_clk);
        check("rst_app_rdy", app_rdy, 0);
        check("rst_wdf_rdy", app_wdf_rdy, 0);
        check("rst_valid", app_rd_data_valid, 0);
        check("rst_rd_data", app_rd_data, 0);
        check("rst_calib", init_calib_complete, 0);
        check("rst_cmd_err", cmd_err, 0);
        @(posedge ui_clk); #1;
        ui_clk_sync_rst = 1'b0;
        rel0 = cyc;

        // Calibration timing.
        repeat (CALIB_CYCLES - 1) @(posedge ui_clk);
        @(negedge ui_clk);
        check("calib_low", init_calib_complete, 0);
        check("calib_app_rdy_low", app_rdy, 0);
        check("calib_wdf_rdy_low", app_wdf_rdy, 0);
        @(posedge ui_clk);
        @(negedge ui_clk);
        check("calib_high", init_calib_complete, 1);
        check("run_app_rdy", app_rdy, 1);
        check("run_wdf_rdy", app_wdf_rdy, 1);
        @(posedge ui_clk); #1;

        // Ten combined writes then back-to-back reads.
        for (int i = 0; i < 10; i++) wr(ADDR_W'(8 * i), DATA_W'(2 * (i + 1)), '0);
        for (int i = 0; i < 10; i++) rd(ADDR_W'(8 * i));
        drain();

        // Data ahead of commands.
        xfer(1'b0, CMD_WRITE, '0, 1'b1, DATA_W'(8'hAA), '0);
        xfer(1'b0, CMD_WRITE, '0, 1'b1, DATA_W'(8'hBB), '0);
        xfer(1'b1, CMD_WRITE, ADDR_W'(16), 1'b0, '0, '0);
        model_write(ADDR_W'(16), DATA_W'(8'hAA), '0);
        xfer(1'b1, CMD_WRITE, ADDR_W'(24), 1'b0, '0, '0);
        model_write(ADDR_W'(24), DATA_W'(8'hBB), '0);
        rd(ADDR_W'(16));
        rd(ADDR_W'(24));
        drain();

        // Command ahead of data blocks further commands.
        xfer(1'b1, CMD_WRITE, ADDR_W'(40), 1'b0, '0, '0);
        repeat (3) begin
            @(negedge ui_clk);
            check("rdy_blocked", app_rdy, 0);
        end
        @(posedge ui_clk); #1;
        xfer(1'b0, CMD_WRITE, '0, 1'b1, DATA_W'(8'hCC), '0);
        model_write(ADDR_W'(40), DATA_W'(8'hCC), '0);
        rd(ADDR_W'(40));
        drain();

        // Byte mask.
        wr(ADDR_W'(0), {DATA_W{1'b1}}, '0);
        wr(ADDR_W'(0), '0, 32'hFFFF_FFFE);
        check("mask_model", model[0], {{(DATA_W-8){1'b1}}, 8'h00});
        rd(ADDR_W'(0));
        drain();

        // Refresh stall pattern under a continuous write stream.
        stall_chk = 1'b1;
        for (int i = 0; i < 16; i++) wr(ADDR_W'(8 * (20 + i)), DATA_W'(7 * i + 100), '0);
        stall_chk = 1'b0;
        for (int i = 0; i < 16; i++) rd(ADDR_W'(8 * (20 + i)));
        drain();

        // Unsupported command: flagged, memory untouched.
        wr(ADDR_W'(48), DATA_W'(32'h1234_5678), '0);
        check("cmd_err_before", cmd_err, 0);
        xfer(1'b1, 3'b010, ADDR_W'(48), 1'b0, '0, '0);
        @(negedge ui_clk);
        check("cmd_err_set", cmd_err, 1);
        @(posedge ui_clk); #1;
        rd(ADDR_W'(48));
        drain();

        // Reset with reads in flight.
        rd(ADDR_W'(0));
        rd(ADDR_W'(8));
        rd(ADDR_W'(16));
        sb.delete();
        ui_clk_sync_rst = 1'b1;
        repeat (2) @(posedge ui_clk);
        @(negedge ui_clk);
        check("rst2_valid", app_rd_data_valid, 0);
        check("rst2_calib", init_calib_complete, 0);
        check("rst2_cmd_err", cmd_err, 0);
        @(posedge ui_clk); #1;
        ui_clk_sync_rst = 1'b0;
        rel0 = cyc;
        begin
            int t;
            t = 0;
            while (init_calib_complete !== 1'b1 && t < 60) begin @(posedge ui_clk); #1; t++; end
            check("recal_done", init_calib_complete, 1);
        end
        rd(ADDR_W'(0));
        rd(ADDR_W'(8));
        rd(ADDR_W'(16));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
